// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state encodings and iterative-engine modes
//               shared by the sequential ALU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_NOR   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_iter.sv
// ============================================================================
// Module      : alu_seq_iter
// Description : Shared WIDTH-step engine: shift-add unsigned multiply and
//               restoring unsigned divide over one 2*WIDTH accumulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  iter_mode_e       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [CW-1:0]      r_cnt;
    iter_mode_e         r_mode;
    logic               r_active;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits / quotient bits}. The shifted
    // remainder needs WIDTH+1 bits; bit WIDTH of the trial is the borrow.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_opb};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_div_next = {(w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_fits};

    assign w_acc_next = (r_mode == MODE_DIV) ? w_div_next : w_mul_next;

    // Results are presented combinationally on the last step so the caller
    // can register them on the same edge the engine goes idle.
    assign finish = r_active && (r_cnt == CW'(WIDTH - 1));
    assign hi     = w_acc_next[2*WIDTH-1:WIDTH];
    assign lo     = w_acc_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_mode   <= MODE_MUL;
            r_active <= 1'b0;
        end else if (start) begin
            r_acc    <= {{WIDTH{1'b0}}, a};
            r_opb    <= b;
            r_cnt    <= '0;
            r_mode   <= mode;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (finish) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle execute-stage ALU with start/busy/done handshake,
//               single-cycle logic/arith/shift ops and iterative MULTU/DIVU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [3:0]       alu_operation_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] alu_data_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             div_zero_o
);

    alu_state_e       r_state;
    alu_state_e       w_state_next;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dz;

    logic             w_iter_start;
    iter_mode_e       w_iter_mode;
    logic             w_iter_finish;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;
    logic             w_sc_load;
    logic             w_iter_load;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sc_data;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_ovf;
    logic             w_sc_dz;

    assign w_sum   = a_i + b_i;
    assign w_diff  = a_i - b_i;
    assign w_shamt = b_i[SHW-1:0];

    // Single-cycle result; DIVU only reaches this path when b_i is zero.
    always_comb begin
        w_sc_data = '0;
        w_sc_hi   = '0;
        w_sc_ovf  = 1'b0;
        w_sc_dz   = 1'b0;
        case (alu_operation_i)
            ALU_AND: w_sc_data = a_i & b_i;
            ALU_OR:  w_sc_data = a_i | b_i;
            ALU_NOR: w_sc_data = ~(a_i | b_i);
            ALU_ADD: begin
                w_sc_data = w_sum;
                w_sc_ovf  = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                w_sc_data = w_diff;
                w_sc_ovf  = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SLT: w_sc_data = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLL: w_sc_data = a_i << w_shamt;
            ALU_SRL: w_sc_data = a_i >> w_shamt;
            ALU_DIVU: begin
                w_sc_data = '1;
                w_sc_hi   = a_i;
                w_sc_dz   = 1'b1;
            end
            default: begin
                w_sc_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_iter_start = 1'b0;
        w_iter_mode  = MODE_MUL;
        w_sc_load    = 1'b0;
        w_iter_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (alu_operation_i == ALU_MULTU) begin
                        w_iter_start = 1'b1;
                        w_iter_mode  = MODE_MUL;
                        w_state_next = ST_MUL;
                    end else if ((alu_operation_i == ALU_DIVU) && (b_i != '0)) begin
                        w_iter_start = 1'b1;
                        w_iter_mode  = MODE_DIV;
                        w_state_next = ST_DIV;
                    end else begin
                        w_sc_load    = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_iter_finish) begin
                    w_iter_load  = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data <= '0;
            r_hi   <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_dz   <= 1'b0;
        end else if (w_sc_load) begin
            r_data <= w_sc_data;
            r_hi   <= w_sc_hi;
            r_zero <= (w_sc_data == '0);
            r_ovf  <= w_sc_ovf;
            r_dz   <= w_sc_dz;
        end else if (w_iter_load) begin
            r_data <= w_iter_lo;
            r_hi   <= w_iter_hi;
            r_zero <= (w_iter_lo == '0);
            r_ovf  <= 1'b0;
            r_dz   <= 1'b0;
        end
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_iter_start),
        .mode    (w_iter_mode),
        .a       (a_i),
        .b       (b_i),
        .finish  (w_iter_finish),
        .hi      (w_iter_hi),
        .lo      (w_iter_lo)
    );

    assign busy_o     = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign done_o     = (r_state == ST_DONE);
    assign alu_data_o = r_data;
    assign hi_o       = r_hi;
    assign zero_o     = r_zero;
    assign overflow_o = r_ovf;
    assign div_zero_o = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq: directed corner cases plus
//               random operations, checking results, flags and latency.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start_i = 1'b0;
    logic [3:0]   alu_operation_i = 4'd0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o, zero_o, overflow_o, div_zero_o;
    logic [W-1:0] alu_data_o, hi_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        logic         dz;
        int           lat;
        int           busy;
    } exp_t;

    exp_t sb_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .alu_data_o      (alu_data_o),
        .hi_o            (hi_o),
        .zero_o          (zero_o),
        .overflow_o      (overflow_o),
        .div_zero_o      (div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint s;
        logic [63:0] p;
        e.data = '0; e.hi = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1; e.busy = 0;
        case (op)
            ALU_AND: e.data = a & b;
            ALU_OR:  e.data = a | b;
            ALU_NOR: e.data = ~(a | b);
            ALU_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                e.data = s[W-1:0];
                e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                e.data = s[W-1:0];
                e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SLT: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: e.data = a << b[4:0];
            ALU_SRL: e.data = a >> b[4:0];
            ALU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.data = p[31:0];
                e.hi   = p[63:32];
                e.lat  = W + 1;
                e.busy = W;
            end
            ALU_DIVU: begin
                if (b == 0) begin
                    e.data = '1;
                    e.hi   = a;
                    e.dz   = 1'b1;
                end else begin
                    e.data = a / b;
                    e.hi   = a % b;
                    e.lat  = W + 1;
                    e.busy = W;
                end
            end
            default: e.data = '0;
        endcase
        e.zero = (e.data == 0);
        return e;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_data"}, 64'(alu_data_o), 64'd0);
        check({tag, "_hi"},   64'(hi_o), 64'd0);
        check({tag, "_flags"}, {61'd0, zero_o, overflow_o, div_zero_o}, 64'd0);
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input int abort_at);
        exp_t e;
        int   lat = 0;
        int   busy_cnt = 0;
        bit   seen = 0;
        alu_operation_i = op;
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        sb_q.push_back(model(op, a, b));
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy_o) busy_cnt++;
            if (done_o) seen = 1;
            start_i = 1'b0;
            alu_operation_i = 4'($urandom);
            a_i = $urandom;
            b_i = $urandom;
            if (lat == inject_at) begin
                start_i = 1'b1;
                alu_operation_i = ALU_ADD;
            end
            if (lat == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                check_reset_state("abort");
                reset_n = 1'b1;
                void'(sb_q.pop_back());
                return;
            end
        end
        if (!seen) begin
            check("timeout", 64'd0, 64'd1);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        check("data", 64'(alu_data_o), 64'(e.data));
        check("hi",   64'(hi_o), 64'(e.hi));
        check("zero", 64'(zero_o), 64'(e.zero));
        check("ovf",  64'(overflow_o), 64'(e.ovf));
        check("dz",   64'(div_zero_o), 64'(e.dz));
        check("latency", 64'(lat), 64'(e.lat));
        check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
        @(negedge clk);
        check("done_pulse", 64'(done_o), 64'd0);
        check("hold_data", 64'(alu_data_o), 64'(e.data));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] rb;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_op(ALU_ADD,   32'h7FFFFFFF, 32'd1, -1, -1);
        run_op(ALU_SUB,   32'd5, 32'd5, -1, -1);
        run_op(ALU_SUB,   32'h80000000, 32'd1, -1, -1);
        run_op(ALU_SLT,   32'hFFFFFFFF, 32'd1, -1, -1);
        run_op(ALU_NOR,   32'h0F0F0000, 32'h00000F0F, -1, -1);
        run_op(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
        run_op(ALU_DIVU,  32'd100, 32'd7, -1, -1);
        run_op(ALU_DIVU,  32'd9, 32'd0, -1, -1);
        run_op(ALU_MULTU, 32'h12345678, 32'h9ABCDEF0, 5, -1);
        run_op(4'hF,      32'h1234, 32'h5678, -1, -1);
        run_op(ALU_DIVU,  32'd1000, 32'd3, -1, 10);
        run_op(ALU_SLL,   32'd1, 32'd31, -1, -1);
        run_op(ALU_SRL,   32'h80000000, 32'd31, -1, -1);

        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(0, 11));
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            run_op(rop, 32'($urandom), rb, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds a start/busy/done handshake and registered results.
- Executes single-cycle logic, arithmetic and shift ops, plus iterative unsigned multiply (shift-add) and unsigned divide (restoring), both WIDTH cycles.
- Sits in the MIPS execute stage; the control unit stalls the pipeline while busy_o=1.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width taken from b_i[SHW-1:0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start_i  input  1  launch an operation; sampled only in IDLE.
- alu_operation_i  input  4  operation code, captured with start_i.
- a_i  input  WIDTH  operand A, captured with start_i.
- b_i  input  WIDTH  operand B, captured with start_i.
- busy_o  output  1  1 while an operation is in flight (after the start cycle until done).
- done_o  output  1  one-cycle pulse; result outputs valid from this cycle.
- alu_data_o  output  WIDTH  result (product low half or quotient for MULTU/DIVU).
- hi_o  output  WIDTH  product high half (MULTU), remainder (DIVU), else 0.
- zero_o  output  1  alu_data_o == 0, registered with result.
- overflow_o  output  1  signed overflow for ADD/SUB, else 0.
- div_zero_o  output  1  DIVU with b_i==0.

Behaviour:
- Reset (reset_n=0 at a rising edge): FSM→IDLE. busy_o, done_o, zero_o, overflow_o, div_zero_o = 0; alu_data_o, hi_o = 0. Any in-flight op is aborted, with no done pulse.
- Op codes:
  - 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB.
  - 0101 SLT: signed compare; result 1/0, zero-extended.
  - 0110 SLL: a_i << b_i[SHW-1:0].
  - 0111 SRL: a_i >> b_i[SHW-1:0], logical.
  - 1000 MULTU, 1001 DIVU.
  - Any other code: result 0, hi 0, zero_o=1, latency 1.
- ADD/SUB wrap modulo 2^WIDTH. overflow_o = operand signs equal (ADD) or differ (SUB), and the result sign differs from A.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + start_i + single-cycle op → compute combinationally, register results, go to DONE. done_o=1 on the next cycle (latency 1); busy_o stays 0.
  - IDLE + start_i + MULTU → latch operands, clear the 2*WIDTH accumulator and counter, go to MUL. busy_o=1.
  - MUL: each cycle, if the multiplier LSB is set, add the multiplicand to the accumulator's upper half; shift right one bit. After WIDTH iterations go to DONE. Latency = WIDTH+1 cycles from start to the done_o cycle.
  - IDLE + start_i + DIVU, b_i≠0 → go to DIV. Run WIDTH restoring iterations (shift remainder, trial subtract, set quotient bit), then DONE. Same latency, WIDTH+1.
  - DIVU with b_i==0 → no iteration; alu_data_o = all ones, hi_o = a_i, div_zero_o=1, DONE next cycle.
  - DONE: done_o=1 for exactly one cycle; busy_o=0; return to IDLE. A start_i in DONE is ignored.
- Result outputs hold their value until the next done_o or reset. Flags are updated only with results.
- start_i while busy_o=1 is ignored; operand/opcode changes while busy have no effect.
- Back-to-back: start_i is accepted in IDLE the cycle after DONE. Peak throughput is one single-cycle op every 2 cycles.
- Reset asserted mid-MUL/DIV takes priority over all FSM transitions.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams (ALU_AND…ALU_DIVU, keeping ADD=4'b0011).
  - FSM state encodings.
- One natural sub-module: alu_seq_iter, the shared iterative engine (accumulator, counter, mul/div datapath) with start/mode in and finish/hi/lo out.
- Single-cycle ops stay in the top module.

Test Plan:
- Reset release, then ADD a=32'h7FFFFFFF b=1 → done_o 1 cycle after start; alu_data_o=32'h80000000, overflow_o=1, zero_o=0, busy_o never 1.
- SUB a=5 b=5 → alu_data_o=0, zero_o=1. SLT a=32'hFFFFFFFF b=1 → alu_data_o=1.
- MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF → busy_o high 32 cycles, done_o at cycle 33; hi_o=32'hFFFFFFFE, alu_data_o=1.
- DIVU a=100 b=7 → alu_data_o=14, hi_o=2 at cycle 33. DIVU a=9 b=0 → alu_data_o=32'hFFFFFFFF, hi_o=9, div_zero_o=1, done after 1 cycle.
- Start MULTU, pulse start_i with ADD at cycle 5 → ignored; MULTU result unaffected; exactly one done_o.
- Assert reset_n=0 at cycle 10 of DIVU → next edge: busy_o=0, outputs 0, no done_o; a subsequent SLL a=1 b=31 → alu_data_o=32'h80000000.
